// File: rtl/wfg_pkg.sv
// Shared definitions for the waveform generator and its PWM output stage.
package wfg_pkg;

    // Default sample/duty width; the PWM period is 2^WIDTH-1 cycles.
    localparam int WFG_WIDTH = 8;

    // Last counter value of a PWM period at the default width.
    localparam int PERIOD_LAST = (2 ** WFG_WIDTH) - 2;

    // Gain code that represents a gain of exactly 1.0.
    localparam logic [4:0] AMP_UNITY = 5'd16;

    // PWM output stage states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Waveform generator function codes.
    typedef enum logic [1:0] {
        FUNC_SINE,
        FUNC_SQUARE,
        FUNC_TRIANGLE,
        FUNC_SAW
    } func_t;

endpackage

// File: rtl/pwm_amplitude_scaler.sv
// Combinational gain stage: clamp the gain code to unity, multiply, drop 4 fraction bits.
module pwm_amplitude_scaler
    import wfg_pkg::*;
#(
    parameter int WIDTH = WFG_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [4:0]       amplitude,
    output logic [WIDTH-1:0] scaled
);

    logic [4:0]       gain;
    logic [WIDTH+4:0] product;

    // Gains above unity are clamped, so the shifted product always fits in WIDTH bits.
    assign gain    = (amplitude > AMP_UNITY) ? AMP_UNITY : amplitude;
    assign product = (WIDTH+5)'(value) * (WIDTH+5)'(gain);
    assign scaled  = WIDTH'(product >> 4);

endmodule

// File: rtl/waveform_pwm_dac.sv
// PWM output stage: latches a gain-scaled sample at each period boundary and
// drives a single-bit PWM signal for an external RC reconstruction filter.
module waveform_pwm_dac
    import wfg_pkg::*;
#(
    parameter int WIDTH = WFG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    input  logic [4:0]       amplitude,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] duty,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] duty_nxt;
    logic [WIDTH-1:0] pending, next_pending;
    logic [WIDTH-1:0] scaled;
    logic             load;

    // A sample arriving on the load edge itself is used straight away.
    assign next_pending = sample_valid ? sample : pending;

    pwm_amplitude_scaler #(.WIDTH(WIDTH)) u_scaler (
        .value     (next_pending),
        .amplitude (amplitude),
        .scaled    (scaled)
    );

    // Next-state logic: period sequencing, duty load decision and counter advance.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        duty_nxt  = duty;
        load      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (en) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        duty_nxt  = '0;
                    end
                end else begin
                    // Dropping en lets the current period finish; raising it again resumes seamlessly.
                    state_nxt = en ? RUN : DRAIN;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (load) begin
            duty_nxt = scaled;
        end
    end

    // State, counter, duty and period strobe registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            duty         <= '0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            duty         <= duty_nxt;
            period_start <= load;
        end
    end

    // Pending sample register: last valid sample wins, kept across period loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else if (sample_valid) begin
            pending <= sample;
        end
    end

    // Outputs are decoded from registers only; duty is zero whenever idle.
    assign busy    = (state != IDLE);
    assign pwm_out = busy && (cnt < duty);

endmodule

// File: tb/tb_waveform_pwm_dac.sv
// Self-checking bench for waveform_pwm_dac: directed scenarios plus random
// stimulus, all compared every cycle against a period-level reference model.
module tb_waveform_pwm_dac;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] sample;
    logic       sample_valid;
    logic [4:0] amplitude;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Reference model: a period is either in progress (with a phase 0..254) or not.
    bit m_busy;
    int m_phase;
    int m_duty;
    int m_pend;
    bit m_ps;

    always #5 clk = ~clk;

    waveform_pwm_dac #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .amplitude    (amplitude),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty         (duty),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int nxt;
        int gain;
        if (rst) begin
            m_busy = 0; m_phase = 0; m_duty = 0; m_pend = 0; m_ps = 0;
            return;
        end
        nxt  = sample_valid ? int'(sample) : m_pend;
        gain = (amplitude > 16) ? 16 : int'(amplitude);
        if (sample_valid) m_pend = int'(sample);
        m_ps = 0;
        if (!m_busy || m_phase == 254) begin
            m_phase = 0;
            if (en) begin
                m_busy = 1;
                m_duty = (nxt * gain) / 16;
                m_ps   = 1;
            end else begin
                m_busy = 0;
                m_duty = 0;
            end
        end else begin
            m_phase++;
        end
    endtask

    // One clock: update the model at the edge, then compare outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pwm_out", pwm_out, (m_busy && m_phase < m_duty) ? 1 : 0);
        check("period_start", period_start, m_ps);
        check("busy", busy, m_busy);
        check("duty", duty, m_duty);
    endtask

    task automatic wait_load();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!m_ps && n < 600);
        check("wait_load_reached", m_ps, 1);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 600 && !(m_busy && m_phase == p); i++) tick();
        check("wait_phase_reached", m_phase, p);
    endtask

    // Starting on a period_start cycle, measure period length and high time from the DUT.
    task automatic measure_period(input string tag, input int exp_highs);
        int highs;
        int len;
        highs = int'(pwm_out);
        len   = 1;
        tick();
        while (!period_start && len < 300) begin
            highs += int'(pwm_out);
            len++;
            tick();
        end
        check({tag, "_len"}, len, 255);
        check({tag, "_highs"}, highs, exp_highs);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; sample = 8'd0; sample_valid = 1'b0; amplitude = 5'd16;
        m_busy = 0; m_phase = 0; m_duty = 0; m_pend = 0; m_ps = 0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_pwm", pwm_out, 0);

        // Reset mid-period with duty 200.
        rst = 1'b0; en = 1'b1; sample = 8'd200; sample_valid = 1'b1;
        wait_phase(100);
        check("mid_duty200", duty, 200);
        rst = 1'b1;
        tick();
        check("rst_pwm", pwm_out, 0);
        check("rst_duty", duty, 0);
        check("rst_busy", busy, 0);
        check("rst_ps", period_start, 0);
        rst = 1'b0;
        tick();
        check("rst_restart_ps", period_start, 1);
        check("rst_restart_busy", busy, 1);

        // Nominal duty.
        sample = 8'd128; amplitude = 5'd16;
        wait_load();
        check("nominal_duty", duty, 128);
        measure_period("nominal_p1", 128);
        measure_period("nominal_p2", 128);

        // Gain and clamp.
        sample = 8'd255; amplitude = 5'd8;
        wait_load();
        check("gain_half", duty, 127);
        amplitude = 5'd20;
        wait_load();
        check("gain_clamp", duty, 255);
        amplitude = 5'd0;
        wait_load();
        measure_period("amp0", 0);

        // Extremes: full-on across three boundaries, then full-off.
        amplitude = 5'd16; sample = 8'd255;
        wait_load();
        for (int i = 0; i < 3 * 255 + 2; i++) begin
            tick();
            check("full_on", pwm_out, 1);
        end
        sample = 8'd0;
        wait_load();
        for (int i = 0; i < 300; i++) begin
            tick();
            check("full_off", pwm_out, 0);
        end

        // Sample coalescing mid-period, then a sample on the load edge.
        sample = 8'd128;
        wait_load();
        sample_valid = 1'b0;
        wait_phase(50);
        sample_valid = 1'b1;
        sample = 8'd10; tick();
        sample = 8'd50; tick();
        sample = 8'd90; tick();
        sample_valid = 1'b0;
        check("coalesce_current", duty, 128);
        wait_load();
        check("coalesce_next", duty, 90);
        wait_phase(254);
        sample = 8'd200; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("bypass_duty", duty, 200);
        check("bypass_ps", period_start, 1);

        // Drain: en dropped at cnt=100, busy falls after cnt=254.
        wait_phase(100);
        en = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 400);
        check("drain_len", n, 155);
        check("drain_duty", duty, 0);

        // Re-arm during drain: no gap, normal boundary.
        en = 1'b1;
        tick();
        check("rearm_start_ps", period_start, 1);
        wait_phase(100);
        en = 1'b0;
        wait_phase(180);
        en = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 400);
        check("rearm_boundary", n, 75);
        check("rearm_busy", busy, 1);

        // en dropped exactly on the last cycle of a period.
        wait_phase(254);
        en = 1'b0;
        tick();
        check("last_drop_busy", busy, 0);
        check("last_drop_ps", period_start, 0);
        for (int i = 0; i < 10; i++) tick();

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) en = ~en;
            rst          = ($urandom_range(999) == 0);
            sample_valid = ($urandom_range(3) == 0);
            sample       = 8'($urandom);
            if ($urandom_range(31) == 0) amplitude = 5'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
